pwm_breathe_multi: RTL and testbench
====================================

// Module: pwm_breathe_multi
// PURPOSE
//   Multi-channel PWM LED driver for RGB or other LED banks. It generalises the single-LED breathing generator
//   into NUM_CH independent channels. Each channel has a runtime mode (OFF / ON / BREATHE / BLINK) and a
//   brightness ceiling (level). All channels share one PWM period counter and one breathe-rate divider.
//   The block sits between top-level control logic (buttons, UART cmd decoder) and the LED pins.
// PARAMETERS
//   NUM_CH       3       number of LED channels
//   PERIOD       12000   PWM period in CLK cycles (1 kHz at 12 MHz); counter runs 0..PERIOD-1
//   STEP         240     duty increment/decrement per breathe update; legal range 1..PERIOD
//   BREATHE_DIV  5       PWM periods per breathe/blink update; must be >= 1
//   (localparam) CNT_W = $clog2(PERIOD+1); width of the counter, duty and level values
// PORTS
//   CLK          in   1              system clock, 12 MHz
//   RST          in   1              synchronous reset, active-high
//   cfg_we       in   1              config write strobe, one cycle
//   cfg_ch       in   $clog2(NUM_CH) target channel (min width 1)
//   cfg_mode     in   2              00 OFF, 01 ON, 10 BREATHE, 11 BLINK
//   cfg_level    in   CNT_W          brightness ceiling, in CLK cycles of ON time
//   LED          out  NUM_CH         registered PWM outputs
//   period_tick  out  1              one-cycle pulse, once per PWM period
// BEHAVIOUR
//   Reset (RST=1 at posedge) sets:
//     cnt=0, div=0, LED=0, period_tick=0.
//     Per channel: duty=0, mode=OFF, level=PERIOD, dir=UP.
//   Period counter:
//     cnt increments each cycle; pe = (cnt==PERIOD-1).
//     When pe is high, cnt wraps to 0 on the next edge.
//   Update tick:
//     upd = pe && (div==BREATHE_DIV-1).
//     div increments on pe and wraps to 0 on upd, so one update occurs every BREATHE_DIV periods.
//   Outputs:
//     LED[i] <= (cnt < duty[i]); one cycle of latency from cnt to pin.
//     period_tick <= pe.
//   Duty changes only on pe edges, so no PWM period is ever truncated or glitched.
//   Config write (cfg_we=1, cfg_ch<NUM_CH):
//     mode[cfg_ch] and level[cfg_ch] load on the next edge.
//     level stores min(cfg_level, PERIOD).
//     dir resets to UP. duty is NOT cleared; BREATHE resumes from the current duty.
//     cfg_ch>=NUM_CH: the write is ignored and no state changes.
//   Per-channel duty update on pe, using the mode and level values held before the edge:
//     OFF:     duty <= 0.
//     ON:      duty <= level.
//     BREATHE, only when upd:
//       UP:   if duty+STEP <= level then duty += STEP, else duty = level and dir = DOWN.
//       DOWN: if duty >= STEP then duty -= STEP, else duty = 0 and dir = UP.
//       Use a CNT_W+1 bit sum so the comparison cannot overflow.
//       If duty > level (level lowered mid-breathe), duty = level and dir = DOWN.
//     BLINK, only when upd:
//       duty <= (duty==0) ? level : 0.
//       level==0 holds the channel dark.
//   Simultaneous cfg_we and pe:
//     The pe update uses the old mode/level; the new config takes effect at the next pe.
//   Reset mid-operation returns every register to its reset value within one edge.
//   The first period after reset has all LEDs dark.
// STRUCTURE
//   Package pwm_pkg:
//     Mode encodings MODE_OFF/ON/BREATHE/BLINK (2-bit).
//     Direction constants DIR_UP/DIR_DOWN.
//   Sub-module pwm_channel:
//     One instance per channel via a generate loop.
//     Holds mode, level, dir and duty, plus the compare register for LED.
//     Inputs: cnt, pe, upd, a per-channel write enable, cfg_mode, cfg_level.
//   Top level holds cnt, div, period_tick, channel-select decode and level clamp.
// TESTING (bench params: NUM_CH=2, PERIOD=10, STEP=3, BREATHE_DIV=2)
//   1. Reset, no writes -> LED=00 throughout; period_tick pulses every 10 cycles.
//   2. ch0 BREATHE, level=10 -> duty per update: 0,3,6,9,10,7,4,1,0,3.
//      Each value holds 2 periods; LED[0] high for exactly duty cycles per period.
//   3. ch1 ON, level=4 -> from the next period on, LED[1] high 4 of every 10 cycles; ch0 unaffected.
//   4. ch0 BLINK, level=10 -> LED[0] alternates 2 periods fully on and 2 periods fully off.
//   5. cfg_level=15 -> clamped, LED fully on for ON mode.
//      cfg_ch=2 -> no change.
//      cfg_we on a pe cycle -> the change is seen one period later.
//   6. RST asserted mid-breathe (duty=6, dir=DOWN) -> next cycle all state returns to reset values;
//      LED=0 until a new config is written.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode and direction encodings for the multi-channel PWM LED driver
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one LED channel holding mode, level, breathe direction, duty and the PWM compare register
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int PERIOD = 12000,
    parameter int STEP   = 240,
    parameter int CNT_W  = $clog2(PERIOD + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             pe_i,
    input  logic             upd_i,
    input  logic             we_i,
    input  mode_e            mode_i,
    input  logic [CNT_W-1:0] level_i,
    output logic             led_o
);

    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] STEP_N  = CNT_W'(STEP);
    localparam logic [CNT_W:0]   STEP_X  = (CNT_W + 1)'(STEP);

    mode_e            mode_q;
    dir_e             dir_q;
    dir_e             dir_d;
    dir_e             brth_dir;
    logic [CNT_W-1:0] level_q;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] duty_d;
    logic [CNT_W-1:0] brth_duty;
    logic [CNT_W:0]   sum;
    logic             up_ok;
    logic             dn_ok;
    logic             led_q;

    // breathe step: ramp toward level and bounce at both ends; a lowered level pulls duty down at once
    always_comb begin
        sum       = {1'b0, duty_q} + STEP_X;
        up_ok     = sum <= {1'b0, level_q};
        dn_ok     = duty_q >= STEP_N;
        brth_duty = duty_q;
        brth_dir  = dir_q;
        if (duty_q > level_q) begin
            brth_duty = level_q;
            brth_dir  = DIR_DOWN;
        end else if (dir_q == DIR_UP) begin
            brth_duty = up_ok ? sum[CNT_W-1:0] : level_q;
            brth_dir  = up_ok ? DIR_UP : DIR_DOWN;
        end else begin
            brth_duty = dn_ok ? duty_q - STEP_N : '0;
            brth_dir  = dn_ok ? DIR_DOWN : DIR_UP;
        end
    end

    // duty only moves on the period edge, using the mode/level held before that edge
    always_comb begin
        duty_d = duty_q;
        dir_d  = dir_q;
        if (pe_i) begin
            case (mode_q)
                MODE_OFF: duty_d = '0;
                MODE_ON:  duty_d = level_q;
                MODE_BREATHE: begin
                    duty_d = upd_i ? brth_duty : duty_q;
                    dir_d  = upd_i ? brth_dir : dir_q;
                end
                default: duty_d = upd_i ? ((duty_q == '0) ? level_q : '0) : duty_q;
            endcase
        end
        if (we_i) dir_d = DIR_UP;
    end

    // channel state plus the registered compare that drives the pin one cycle after cnt
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_OFF;
            level_q <= LVL_MAX;
            dir_q   <= DIR_UP;
            duty_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= we_i ? mode_i : mode_q;
            level_q <= we_i ? level_i : level_q;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            led_q   <= cnt_i < duty_q;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/pwm_breathe_multi.sv
// pwm_breathe_multi: NUM_CH-channel PWM LED driver with shared period counter and breathe-rate divider
module pwm_breathe_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int PERIOD      = 12000,
    parameter int STEP        = 240,
    parameter int BREATHE_DIV = 5
) (
    input  logic                                           CLK,
    input  logic                                           RST,
    input  logic                                           cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                     cfg_mode,
    input  logic [$clog2(PERIOD + 1)-1:0]                  cfg_level,
    output logic [NUM_CH-1:0]                              LED,
    output logic                                           period_tick
);

    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
    localparam logic [CNT_W-1:0] LVL_MAX = CNT_W'(PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             pe;
    logic             upd;
    logic [CNT_W-1:0] lvl_clamp;
    logic [NUM_CH-1:0] we_ch;

    // period end, update tick, counter/divider next state and level clamp
    always_comb begin
        pe        = cnt_q == CNT_W'(PERIOD - 1);
        upd       = pe && (div_q == DIV_W'(BREATHE_DIV - 1));
        cnt_d     = pe ? '0 : cnt_q + CNT_W'(1);
        div_d     = upd ? '0 : (pe ? div_q + DIV_W'(1) : div_q);
        lvl_clamp = (cfg_level > LVL_MAX) ? LVL_MAX : cfg_level;
    end

    // shared period counter, breathe divider and the registered period pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= pe;
        end
    end

    // out-of-range channel numbers match no instance, so such writes change nothing
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));
        pwm_channel #(
            .PERIOD (PERIOD),
            .STEP   (STEP),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk_i   (CLK),
            .rst_i   (RST),
            .cnt_i   (cnt_q),
            .pe_i    (pe),
            .upd_i   (upd),
            .we_i    (we_ch[i]),
            .mode_i  (mode_e'(cfg_mode)),
            .level_i (lvl_clamp),
            .led_o   (LED[i])
        );
    end

    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// tb_pwm_breathe_multi: scoreboard bench comparing per-period LED on-counts against hand-computed duties
module tb_pwm_breathe_multi;

    localparam int PERIOD = 10;

    localparam int B0 [19] = '{0, 3, 3, 6, 6, 9, 9, 10, 10, 7, 7, 4, 4, 1, 1, 0, 0, 3, 3};
    localparam int C0 [4]  = '{6, 6, 9, 9};
    localparam int C1 [4]  = '{0, 4, 4, 4};
    localparam int D0 [8]  = '{10, 10, 0, 0, 10, 10, 0, 0};
    localparam int F0 [3]  = '{10, 0, 0};
    localparam int F1 [3]  = '{10, 10, 0};
    localparam int G0 [6]  = '{10, 10, 10, 10, 7, 7};
    localparam int H0 [6]  = '{4, 4, 7, 7, 9, 9};

    typedef struct {
        int l0;
        int l1;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_ch = 1'b0;
    logic [1:0] cfg_mode = 2'b00;
    logic [3:0] cfg_level = 4'd0;
    logic [1:0] LED;
    logic       period_tick;
    logic [1:0] cfg_ch3 = 2'd3;
    logic [2:0] led3;
    logic       tick3;
    logic       rst_at_edge;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    pwm_breathe_multi #(
        .NUM_CH(2), .PERIOD(10), .STEP(3), .BREATHE_DIV(2)
    ) dut (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
        .cfg_level(cfg_level), .LED(LED), .period_tick(period_tick)
    );

    pwm_breathe_multi #(
        .NUM_CH(3), .PERIOD(10), .STEP(3), .BREATHE_DIV(2)
    ) dut3 (
        .CLK(CLK), .RST(RST), .cfg_we(cfg_we), .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode),
        .cfg_level(cfg_level), .LED(led3), .period_tick(tick3)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) rst_at_edge <= RST;

    task automatic check(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic push(input int a, input int b);
        exp_t e;
        e.l0 = a;
        e.l1 = b;
        sb.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = 0;
            do begin
                @(negedge CLK);
                c++;
            end while (!period_tick && c < 40);
            if (!period_tick) begin
                total++;
                bad++;
                $display("FAIL tick_timeout got=no_tick want=tick_within_40");
            end
        end
    endtask

    task automatic wcfg(input logic ch, input logic [1:0] mode, input logic [3:0] lvl);
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_level = lvl;
        cfg_we    = 1'b1;
        @(posedge CLK);
        #1 cfg_we = 1'b0;
    endtask

    // monitor: accumulate LED on-cycles per period and score them at each period_tick
    initial begin
        int   acc0, acc1, acc3, cyc, per;
        exp_t e;
        acc0 = 0; acc1 = 0; acc3 = 0; cyc = 0; per = 0;
        forever begin
            @(negedge CLK);
            if (rst_at_edge) begin
                acc0 = 0; acc1 = 0; acc3 = 0; cyc = 0;
            end else begin
                cyc++;
                acc0 += int'(LED[0]);
                acc1 += int'(LED[1]);
                acc3 += int'(led3 != 3'b000);
                if (period_tick) begin
                    check($sformatf("p%0d_len", per), cyc, PERIOD);
                    check($sformatf("p%0d_tick3", per), int'(tick3), 1);
                    check($sformatf("p%0d_badch_dark", per), acc3, 0);
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL p%0d_sb got=empty want=entry", per);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("p%0d_ch0", per), acc0, e.l0);
                        check($sformatf("p%0d_ch1", per), acc1, e.l1);
                    end
                    per++;
                    acc0 = 0; acc1 = 0; acc3 = 0; cyc = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // stimulus: each phase pushes its expected periods, then writes config and waits them out
    initial begin
        for (int k = 0; k < 3; k++) push(0, 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        wait_ticks(3);
        foreach (B0[k]) push(B0[k], 0);
        wcfg(1'b0, 2'b10, 4'd10);
        wait_ticks(19);
        foreach (C0[k]) push(C0[k], C1[k]);
        wcfg(1'b1, 2'b01, 4'd4);
        wait_ticks(4);
        foreach (D0[k]) push(D0[k], 4);
        wcfg(1'b0, 2'b11, 4'd10);
        wait_ticks(8);
        push(10, 4);
        wcfg(1'b1, 2'b01, 4'd15);
        wait_ticks(1);
        foreach (F0[k]) push(F0[k], F1[k]);
        repeat (9) @(posedge CLK);
        #1;
        cfg_ch    = 1'b1;
        cfg_mode  = 2'b00;
        cfg_level = 4'd0;
        cfg_we    = 1'b1;
        @(posedge CLK);
        #1 cfg_we = 1'b0;
        wait_ticks(3);
        foreach (G0[k]) push(G0[k], 0);
        wcfg(1'b0, 2'b10, 4'd15);
        wait_ticks(6);
        foreach (H0[k]) push(H0[k], 0);
        wcfg(1'b0, 2'b10, 4'd9);
        wait_ticks(6);
        for (int k = 0; k < 3; k++) push(0, 0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_led", int'(LED), 0);
        check("rst_tick", int'(period_tick), 0);
        wait_ticks(3);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
